// File: rtl/sg_split_pkg.sv
// sg_split_pkg
//   Shared definitions for the scatter-gather request splitter:
//   FSM state encoding, request sizing constants and REQ_LEN width.
package sg_split_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  // Words in one 4 KB page (4096 B / 4 B per word).
  localparam int WORDS_PER_4K   = 1024;
  // Request size at MAX_REQ_SEL = 0 (128 B).
  localparam int BASE_REQ_WORDS = 32;
  // REQ_LEN must hold 1..1024.
  localparam int REQ_LEN_W      = 11;

endpackage : sg_split_pkg

// File: rtl/sg_chunk_calc.sv
// sg_chunk_calc
//   Combinational chunk sizing for one request.
//   chunk = min(rem, 32 << sel [, words left in the current 4 KB page])
//   Optional feature macro: SG_SPLIT_4K_EN (adds the 4 KB page limit).
// Ports:
//   addr_word  in  10  word offset within the 4 KB page (byte address [11:2])
//   rem        in  32  words remaining in the element (caller guarantees > 0)
//   sel        in  3   size select, already clamped (<= 5 keeps chunk <= 1024)
//   chunk      out 11  words for this request
//   last       out 1   chunk consumes all remaining words
module sg_chunk_calc
  import sg_split_pkg::*;
(
  input  logic [9:0]           addr_word,
  input  logic [31:0]          rem,
  input  logic [2:0]           sel,
  output logic [REQ_LEN_W-1:0] chunk,
  output logic                 last
);

  localparam logic [REQ_LEN_W-1:0] BASE_W = REQ_LEN_W'(BASE_REQ_WORDS);

  logic [REQ_LEN_W-1:0] max_words;
  logic [REQ_LEN_W-1:0] size_chunk;

  assign max_words = BASE_W << sel;

  // rem < max_words implies rem fits in REQ_LEN_W bits.
  assign size_chunk = (rem < 32'(max_words)) ? rem[REQ_LEN_W-1:0] : max_words;

`ifdef SG_SPLIT_4K_EN
  logic [REQ_LEN_W-1:0] words_to_4k;
  // Always 1..1024: a word-aligned address has at least one word left in its page.
  assign words_to_4k = REQ_LEN_W'(WORDS_PER_4K) - {1'b0, addr_word};
  assign chunk = (words_to_4k < size_chunk) ? words_to_4k : size_chunk;
`else
  logic addr_unused;
  assign addr_unused = ^addr_word;
  assign chunk = size_chunk;
`endif

  assign last = (32'(chunk) == rem);

endmodule : sg_chunk_calc

// File: rtl/sg_req_splitter.sv
// sg_req_splitter
//   Splits one scatter-gather element (byte address, word length) into read
//   requests no larger than 128 B << MAX_REQ_SEL and, when SG_SPLIT_4K_EN is
//   defined, never crossing a 4 KB address boundary. Requests are presented
//   one at a time on REQ_VALID/REQ_ACK.
//   Optional feature macro: SG_SPLIT_4K_EN.
//
// Handshake: REQ_VALID rises with REQ_ADDR/REQ_LEN/REQ_LAST registered and
//   holds them stable until a cycle with REQ_ACK=1; that cycle is the transfer
//   and REQ_VALID drops on the next edge. REQ_ACK while REQ_VALID=0 is ignored.
//   SG_REN is a one-cycle registered pulse per accepted element.
//
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   SG_VALID        element available from the reader
//   SG_EMPTY        reader has nothing more buffered (informational)
//   SG_ADDR[63:0]   element byte address (bits [1:0] ignored)
//   SG_LEN[31:0]    element length in words
//   SG_REN          element consume pulse
//   MAX_REQ_SEL[2:0] request size select, clamped to C_MAX_SEL_LIMIT
//   REQ_VALID/REQ_ACK/REQ_ADDR/REQ_LEN/REQ_LAST  request channel
//   SG_DONE         pulse when an element is fully issued or discarded
//   BUSY            FSM not in IDLE
//   dbg_state[1:0]  FSM state (sg_split_pkg::state_t encoding)
module sg_req_splitter
  import sg_split_pkg::*;
#(
  parameter int C_MAX_SEL_LIMIT = 5
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 SG_VALID,
  input  logic                 SG_EMPTY,
  input  logic [63:0]          SG_ADDR,
  input  logic [31:0]          SG_LEN,
  output logic                 SG_REN,
  input  logic [2:0]           MAX_REQ_SEL,
  output logic                 REQ_VALID,
  input  logic                 REQ_ACK,
  output logic [63:0]          REQ_ADDR,
  output logic [REQ_LEN_W-1:0] REQ_LEN,
  output logic                 REQ_LAST,
  output logic                 SG_DONE,
  output logic                 BUSY,
  output logic [1:0]           dbg_state
);

  localparam logic [2:0] SEL_LIM = 3'(C_MAX_SEL_LIMIT);

  state_t               state;
  logic [63:0]          r_addr;
  logic [31:0]          r_rem;
  logic [2:0]           r_sel;
  logic [REQ_LEN_W-1:0] chunk;
  logic                 chunk_last;

  // SG_EMPTY is not used for control; the low address bits are forced to zero.
  logic in_unused;
  assign in_unused = ^{SG_EMPTY, SG_ADDR[1:0]};

  sg_chunk_calc u_chunk_calc (
    .addr_word (r_addr[11:2]),
    .rem       (r_rem),
    .sel       (r_sel),
    .chunk     (chunk),
    .last      (chunk_last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      r_addr    <= '0;
      r_rem     <= '0;
      r_sel     <= '0;
      SG_REN    <= 1'b0;
      REQ_VALID <= 1'b0;
      REQ_ADDR  <= '0;
      REQ_LEN   <= '0;
      REQ_LAST  <= 1'b0;
      SG_DONE   <= 1'b0;
    end else begin
      SG_REN  <= 1'b0;
      SG_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (SG_VALID) begin
            r_addr <= {SG_ADDR[63:2], 2'b00};
            r_rem  <= SG_LEN;
            r_sel  <= (MAX_REQ_SEL > SEL_LIM) ? SEL_LIM : MAX_REQ_SEL;
            SG_REN <= 1'b1;
            // A zero-length element finishes in CALC, so its DONE pulse must
            // already be registered when CALC is entered.
            SG_DONE <= (SG_LEN == 32'd0);
            state  <= S_CALC;
          end
        end

        S_CALC: begin
          if (r_rem == 32'd0) begin
            state <= S_IDLE;
          end else begin
            REQ_ADDR  <= r_addr;
            REQ_LEN   <= chunk;
            REQ_LAST  <= chunk_last;
            REQ_VALID <= 1'b1;
            state     <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (REQ_ACK) begin
            REQ_VALID <= 1'b0;
            // Advance using the registered request so the update matches
            // exactly what was handed downstream.
            r_addr <= r_addr + {51'd0, REQ_LEN, 2'b00};
            r_rem  <= r_rem - {21'd0, REQ_LEN};
            if (REQ_LAST) begin
              SG_DONE <= 1'b1;
              state   <= S_IDLE;
            end else begin
              state <= S_CALC;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = (state != S_IDLE);
  assign dbg_state = state;

endmodule : sg_req_splitter

// File: tb/tb_sg_req_splitter.sv
// tb_sg_req_splitter
//   Directed bench for sg_req_splitter. Expected requests are packed as
//   {addr[63:0], len[10:0], last} into exp_q and popped as requests arrive.
//   Expectations for the 4 KB case follow SG_SPLIT_4K_EN.
module tb_sg_req_splitter;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SG_VALID = 1'b0;
  logic        SG_EMPTY = 1'b1;
  logic [63:0] SG_ADDR = '0;
  logic [31:0] SG_LEN = '0;
  logic        SG_REN;
  logic [2:0]  MAX_REQ_SEL = '0;
  logic        REQ_VALID;
  logic        REQ_ACK = 1'b0;
  logic [63:0] REQ_ADDR;
  logic [10:0] REQ_LEN;
  logic        REQ_LAST;
  logic        SG_DONE;
  logic        BUSY;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int ren_cnt = 0;

  logic [75:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  always @(posedge CLK) if (SG_REN === 1'b1) ren_cnt <= ren_cnt + 1;

  sg_req_splitter #(.C_MAX_SEL_LIMIT(5)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .SG_VALID    (SG_VALID),
    .SG_EMPTY    (SG_EMPTY),
    .SG_ADDR     (SG_ADDR),
    .SG_LEN      (SG_LEN),
    .SG_REN      (SG_REN),
    .MAX_REQ_SEL (MAX_REQ_SEL),
    .REQ_VALID   (REQ_VALID),
    .REQ_ACK     (REQ_ACK),
    .REQ_ADDR    (REQ_ADDR),
    .REQ_LEN     (REQ_LEN),
    .REQ_LAST    (REQ_LAST),
    .SG_DONE     (SG_DONE),
    .BUSY        (BUSY),
    .dbg_state   (dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Presents one element for a single cycle (t) and checks the t+1 / t+2 view.
  task automatic start_element(input logic [63:0] addr, input logic [31:0] len,
                               input logic [2:0] sel);
    int r0;
    r0 = ren_cnt;
    SG_ADDR = addr; SG_LEN = len; MAX_REQ_SEL = sel; SG_VALID = 1'b1;
    @(negedge CLK);
    SG_VALID = 1'b0;
    n_cmp++;
    if (SG_REN !== 1'b1 || BUSY !== 1'b1 || SG_DONE !== (len == 0)) begin
      n_err++;
      $display("FAIL start_t1: ren=%b busy=%b done=%b, required ren=1 busy=1 done=%b",
               SG_REN, BUSY, SG_DONE, (len == 0));
    end
    @(negedge CLK);
    n_cmp++;
    if (SG_REN !== 1'b0 || REQ_VALID !== (len != 0) || ren_cnt != r0 + 1) begin
      n_err++;
      $display("FAIL start_t2: ren=%b valid=%b ren_pulses=%0d, required ren=0 valid=%b ren_pulses=1",
               SG_REN, REQ_VALID, ren_cnt - r0, (len != 0));
    end
  endtask

  // Accepts every queued request; the first is held off for 'hold' cycles.
  task automatic collect(input int hold);
    logic [75:0] e;
    int waited;
    int h;
    h = hold;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      waited = 0;
      while (REQ_VALID !== 1'b1 && waited < 20) begin
        @(negedge CLK);
        waited++;
      end
      n_cmp++;
      if (REQ_VALID !== 1'b1) begin
        n_err++;
        $display("FAIL req_timeout: REQ_VALID=%b after %0d cycles, required 1", REQ_VALID, waited);
        exp_q.delete();
        return;
      end
      n_cmp++;
      if ({REQ_ADDR, REQ_LEN, REQ_LAST} !== e) begin
        n_err++;
        $display("FAIL req_fields: addr=%h len=%0d last=%b, required addr=%h len=%0d last=%b",
                 REQ_ADDR, REQ_LEN, REQ_LAST, e[75:12], e[11:1], e[0]);
      end
      for (int i = 0; i < h; i++) begin
        @(negedge CLK);
        n_cmp++;
        if (REQ_VALID !== 1'b1 || {REQ_ADDR, REQ_LEN, REQ_LAST} !== e) begin
          n_err++;
          $display("FAIL hold_stable: cycle %0d valid=%b addr=%h len=%0d last=%b, required valid=1 addr=%h len=%0d last=%b",
                   i, REQ_VALID, REQ_ADDR, REQ_LEN, REQ_LAST, e[75:12], e[11:1], e[0]);
        end
      end
      h = 0;
      REQ_ACK = 1'b1;
      @(negedge CLK);
      REQ_ACK = 1'b0;
      n_cmp++;
      if (REQ_VALID !== 1'b0 || SG_DONE !== e[0] || BUSY !== !e[0]) begin
        n_err++;
        $display("FAIL after_ack: valid=%b done=%b busy=%b, required valid=0 done=%b busy=%b",
                 REQ_VALID, SG_DONE, BUSY, e[0], !e[0]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge CLK);
    n_cmp++;
    if ({REQ_VALID, SG_REN, SG_DONE, BUSY, REQ_LAST} !== 5'b0 || REQ_ADDR !== 64'd0 ||
        REQ_LEN !== 11'd0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_vals: valid=%b ren=%b done=%b busy=%b addr=%h len=%0d last=%b st=%0d, required all 0",
               REQ_VALID, SG_REN, SG_DONE, BUSY, REQ_ADDR, REQ_LEN, REQ_LAST, dbg_state);
    end
    RST_N = 1'b1;
    REQ_ACK = 1'b1;          // stray ack with no request must be ignored
    @(negedge CLK);
    REQ_ACK = 1'b0;
    @(negedge CLK);
    n_cmp++;
    if (REQ_VALID !== 1'b0 || BUSY !== 1'b0 || SG_DONE !== 1'b0 || SG_REN !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset: valid=%b busy=%b done=%b ren=%b, required 0 0 0 0",
               REQ_VALID, BUSY, SG_DONE, SG_REN);
    end
  endtask

  task automatic test_multi_chunk();
    exp_q.push_back({64'h1000, 11'd128, 1'b0});
    exp_q.push_back({64'h1200, 11'd128, 1'b0});
    exp_q.push_back({64'h1400, 11'd44,  1'b1});
    start_element(64'h1000, 32'd300, 3'd2);
    collect(0);
  endtask

  task automatic test_4k_cross();
`ifdef SG_SPLIT_4K_EN
    exp_q.push_back({64'h0FF0, 11'd4,  1'b0});
    exp_q.push_back({64'h1000, 11'd12, 1'b1});
`else
    exp_q.push_back({64'h0FF0, 11'd16, 1'b1});
`endif
    start_element(64'h0FF0, 32'd16, 3'd5);
    collect(0);
  endtask

  task automatic test_zero_len();
    start_element(64'h5000, 32'd0, 3'd3);
    n_cmp++;
    if (BUSY !== 1'b0 || SG_DONE !== 1'b0) begin
      n_err++;
      $display("FAIL zero_len_idle: busy=%b done=%b, required 0 0", BUSY, SG_DONE);
    end
    // Next element, with address bits [1:0] set that must be dropped.
    exp_q.push_back({64'h0, 11'd5, 1'b1});
    start_element(64'h3, 32'd5, 3'd1);
    collect(0);
  endtask

  task automatic test_backpressure();
    exp_q.push_back({64'h2000, 11'd128, 1'b0});
    exp_q.push_back({64'h2200, 11'd72,  1'b1});
    start_element(64'h2000, 32'd200, 3'd2);
    MAX_REQ_SEL = 3'd0;      // must not affect this element
    collect(5);
  endtask

  task automatic test_clamp_max();
    exp_q.push_back({64'h0,    11'd1024, 1'b0});
    exp_q.push_back({64'h1000, 11'd1024, 1'b1});
    start_element(64'h0, 32'd2048, 3'd7);
    collect(0);
  endtask

  task automatic test_addr_wrap();
    exp_q.push_back({64'hFFFF_FFFF_FFFF_FF80, 11'd32, 1'b0});
    exp_q.push_back({64'h0,                   11'd32, 1'b1});
    start_element(64'hFFFF_FFFF_FFFF_FF80, 32'd64, 3'd0);
    collect(0);
  endtask

  task automatic test_reset_mid_issue();
    start_element(64'h8000, 32'd64, 3'd0);
    #2 RST_N = 1'b0;
    #1;
    n_cmp++;
    if (REQ_VALID !== 1'b0 || BUSY !== 1'b0 || REQ_LEN !== 11'd0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async: valid=%b busy=%b len=%0d st=%0d, required 0 0 0 0",
               REQ_VALID, BUSY, REQ_LEN, dbg_state);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    exp_q.push_back({64'h40, 11'd8, 1'b1});
    start_element(64'h40, 32'd8, 3'd0);
    collect(0);
  endtask

  initial begin
    test_reset();
    test_multi_chunk();
    test_4k_cross();
    test_zero_len();
    test_backpressure();
    test_clamp_max();
    test_addr_wrap();
    test_reset_mid_issue();
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule : tb_sg_req_splitter
